// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo
// Receives PS/2 keyboard frames, validates start/odd-parity/stop, aborts
// frames that stall, folds E0/F0 prefixes into 10-bit codes {ext, brk, scan}
// and queues them in a show-ahead FIFO with a valid/ready interface.
//
// Optional build macro: PS2_RX_TYPEMATIC_FILTER_EN
//   When defined, repeated make codes (keyboard auto-repeat) are discarded
//   until the matching break code or a different make code is seen.
//
// Ports:
//   clk, rst     system clock; asynchronous active-high reset
//   ps2_clk      raw PS/2 clock pin
//   ps2_data     raw PS/2 data pin
//   code_data    FIFO head {ext, brk, scan[7:0]}, 0 when empty
//   code_valid   FIFO not empty
//   code_ready   consumer accepts the head this cycle
//   fifo_count   current FIFO occupancy
//   frame_err    one-cycle pulse on a parity/start/stop/timeout error
//   overflow     sticky; a code was dropped because the FIFO was full
//   clr_err      synchronous clear of overflow (a new overflow wins)
module ps2_rx_fifo #(
  parameter int SYNC_STAGES    = 3,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic [9:0]                    code_data,
  output logic                          code_valid,
  input  logic                          code_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overflow,
  input  logic                          clr_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

  // ---------------------------------------------------------------------
  // Synchronisers and falling-edge detect. Reset to 1 (idle bus) so that
  // releasing reset never manufactures a falling edge.
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_prev;
  logic                   fall, bit_in;

  // NOTE: every clocked process uses non-blocking assignments so that all
  // flops update together and the order of statements cannot create races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fall   = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign bit_in = data_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------------
  // Frame receiver FSM
  // Bits shift in at the MSB, so after 11 falls: [0]=start, [8:1]=data,
  // [9]=parity, [10]=stop.
  // ---------------------------------------------------------------------
  state_t          state, state_nxt;
  logic [10:0]     shreg;
  logic [3:0]      bitcnt;
  logic [TW-1:0]   timer;
  logic            ext, brk, ext_nxt, brk_nxt;
  logic            err, code_done, frame_ok;
  logic [7:0]      frame_byte;
  logic [9:0]      code_in;

  assign frame_byte = shreg[8:1];
  assign frame_ok   = ~shreg[0] & shreg[10] & (^shreg[9:1]);
  assign code_in    = {ext, brk, frame_byte};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    err       = 1'b0;
    code_done = 1'b0;
    ext_nxt   = ext;
    brk_nxt   = brk;
    case (state)
      IDLE:  if (fall) state_nxt = RECV;
      RECV: begin
        if (fall) begin
          if (bitcnt == 4'd10) state_nxt = CHECK;
        end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
          err       = 1'b1;
          ext_nxt   = 1'b0;
          brk_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      CHECK: begin
        state_nxt = IDLE;
        if (!frame_ok) begin
          err     = 1'b1;
          ext_nxt = 1'b0;
          brk_nxt = 1'b0;
        end else if (frame_byte == 8'hE0) begin
          ext_nxt = 1'b1;
        end else if (frame_byte == 8'hF0) begin
          brk_nxt = 1'b1;
        end else begin
          code_done = 1'b1;
          ext_nxt   = 1'b0;
          brk_nxt   = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg     <= '0;
      bitcnt    <= '0;
      timer     <= '0;
      ext       <= 1'b0;
      brk       <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= err;
      ext       <= ext_nxt;
      brk       <= brk_nxt;
      case (state)
        IDLE: if (fall) begin
          shreg  <= {bit_in, shreg[10:1]};
          bitcnt <= 4'd1;
          timer  <= '0;
        end
        RECV: if (fall) begin
          shreg  <= {bit_in, shreg[10:1]};
          bitcnt <= bitcnt + 4'd1;
          timer  <= '0;
        end else begin
          timer  <= timer + TW'(1);
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Optional typematic filter: drop a make code identical to the last one.
  // ---------------------------------------------------------------------
  logic push_req;

`ifdef PS2_RX_TYPEMATIC_FILTER_EN
  logic [9:0] last_make;
  logic       lm_valid;
  logic       is_repeat, brk_match;

  assign is_repeat = ~brk & lm_valid & (code_in == last_make);
  assign brk_match = brk & ({ext, frame_byte} == {last_make[9], last_make[7:0]});
  assign push_req  = code_done & ~is_repeat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_make <= '0;
      lm_valid  <= 1'b0;
    end else if (code_done) begin
      if (brk_match) begin
        lm_valid <= 1'b0;
      end else if (!brk && !is_repeat) begin
        last_make <= code_in;
        lm_valid  <= 1'b1;
      end
    end
  end
`else
  assign push_req = code_done;
`endif

  // ---------------------------------------------------------------------
  // Show-ahead FIFO. A push into a full FIFO succeeds only if the head is
  // popped in the same cycle; otherwise the code is dropped.
  // ---------------------------------------------------------------------
  logic [9:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          pop, push, full;

  assign full       = (count == CW'(FIFO_DEPTH));
  assign code_valid = (count != '0);
  assign pop        = code_valid & code_ready;
  assign push       = push_req & (~full | pop);
  assign code_data  = code_valid ? mem[rd_ptr] : '0;
  assign fifo_count = count;

  // NOTE: the storage array has no reset; code_valid gates every read, so
  // stale contents are never visible and the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= code_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      if (push_req && full && !pop) overflow <= 1'b1;
      else if (clr_err)             overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Self-checking bench for ps2_rx_fifo. A reference model folds prefixes,
// applies the optional typematic filter and queues expected codes; a
// negedge monitor pops and compares every code the DUT hands out.
module tb_ps2_rx_fifo;

  localparam int DEPTH = 8;
  localparam int TMO   = 200;
  localparam int H     = 8;   // clk cycles per PS/2 clock half-period

`ifdef PS2_RX_TYPEMATIC_FILTER_EN
  localparam int TYPE_PUSHES = 2;
`else
  localparam int TYPE_PUSHES = 4;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       code_ready = 1'b0;
  logic       clr_err = 1'b0;
  logic [9:0] code_data;
  logic       code_valid;
  logic [3:0] fifo_count;
  logic       frame_err;
  logic       overflow;

  always #5 clk = ~clk;

  ps2_rx_fifo #(
    .SYNC_STAGES   (3),
    .FIFO_DEPTH    (DEPTH),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .code_data (code_data),
    .code_valid(code_valid),
    .code_ready(code_ready),
    .fifo_count(fifo_count),
    .frame_err (frame_err),
    .overflow  (overflow),
    .clr_err   (clr_err)
  );

  int         vectors = 0;
  int         miscompares = 0;
  int         err_seen = 0;
  int         exp_err = 0;
  int         pops = 0;
  logic [9:0] exp_q[$];
  bit         m_ext, m_brk, lm_v;
  logic [9:0] lm;

  // Scoreboard monitor: a pop happens at the next posedge whenever
  // valid && ready are seen here.
  always @(negedge clk) begin
    logic [9:0] e;
    if (!rst) begin
      if (frame_err) err_seen++;
      if (code_valid && code_ready) begin
        vectors++;
        pops++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL pop_unexpected: got %h, expected no entry", code_data);
        end else begin
          e = exp_q.pop_front();
          if (code_data !== e) begin
            miscompares++;
            $display("FAIL pop_data: got %h, expected %h", code_data, e);
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model of prefix folding, typematic filter and FIFO drop.
  task automatic model_byte(input logic [7:0] b, input bit ok);
    logic [9:0] code;
    bit keep;
    if (!ok) begin
      m_ext = 0; m_brk = 0; exp_err++;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      code = {m_ext, m_brk, b};
      keep = 1;
`ifdef PS2_RX_TYPEMATIC_FILTER_EN
      if (!m_brk && lm_v && code == lm) keep = 0;
      else if (m_brk && {m_ext, b} == {lm[9], lm[7:0]}) lm_v = 0;
      else if (!m_brk) begin lm = code; lm_v = 1; end
`endif
      if (keep && !(exp_q.size() >= DEPTH && !code_ready)) exp_q.push_back(code);
      m_ext = 0; m_brk = 0;
    end
  endtask

  // Drives the first nbits of a frame; a full frame also updates the model.
  task automatic ps2_frame(input logic [7:0] b, input bit bad_par,
                           input int nbits, input bit lat_chk);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      tick(H);
      ps2_clk = 1'b0;
      if (i == 10) begin
        model_byte(b, !bad_par);
        if (lat_chk) begin
          tick(4);
          vectors++;
          if (code_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_early: code_valid=%b, expected 0", code_valid);
          end
          tick(1);
          vectors++;
          if (code_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL latency_rise: code_valid=%b, expected 1", code_valid);
          end
          tick(H - 5);
        end else begin
          tick(H);
        end
      end else begin
        tick(H);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    tick(H);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) tick(1);
    tick(2);
    vectors++;
    if (exp_q.size() != 0 || fifo_count !== 4'd0) begin
      miscompares++;
      $display("FAIL %s_drain: pending=%0d fifo_count=%0d, expected 0 and 0",
               name, exp_q.size(), fifo_count);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    vectors++;
    if ({code_data, code_valid, fifo_count, frame_err, overflow} !== 17'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: data=%h valid=%b count=%0d err=%b ovf=%b, expected all 0",
               code_data, code_valid, fifo_count, frame_err, overflow);
    end
    rst = 1'b0;
    tick(5);
    vectors++;
    if ({code_valid, fifo_count, frame_err} !== 6'd0) begin
      miscompares++;
      $display("FAIL reset_release: valid=%b count=%0d err=%b, expected 0",
               code_valid, fifo_count, frame_err);
    end
  endtask

  task automatic test_basic();
    int e0;
    e0 = err_seen;
    code_ready = 1'b0;
    ps2_frame(8'h1C, 0, 11, 1);
    vectors++;
    if (fifo_count !== 4'd1 || code_data !== 10'h01C) begin
      miscompares++;
      $display("FAIL basic_head: count=%0d data=%h, expected 1 and 01c", fifo_count, code_data);
    end
    code_ready = 1'b1;
    drain("basic");
    vectors++;
    if (err_seen != e0) begin
      miscompares++;
      $display("FAIL basic_err: pulses=%0d, expected 0", err_seen - e0);
    end
  endtask

  task automatic test_prefix();
    int p0;
    p0 = pops;
    code_ready = 1'b1;
    ps2_frame(8'hE0, 0, 11, 0);
    ps2_frame(8'hF0, 0, 11, 0);
    ps2_frame(8'h75, 0, 11, 0);
    drain("prefix_ext_brk");
    ps2_frame(8'hE0, 0, 11, 0);
    ps2_frame(8'h75, 0, 11, 0);
    drain("prefix_ext");
    ps2_frame(8'h1C, 0, 11, 0);
    drain("prefix_cleared");
    vectors++;
    if (pops - p0 != 3) begin
      miscompares++;
      $display("FAIL prefix_count: entries=%0d, expected 3", pops - p0);
    end
  endtask

  task automatic test_parity();
    int e0;
    e0 = err_seen;
    code_ready = 1'b1;
    ps2_frame(8'h5A, 1, 11, 0);
    vectors++;
    if (err_seen != e0 + 1 || fifo_count !== 4'd0) begin
      miscompares++;
      $display("FAIL parity_err: pulses=%0d count=%0d, expected 1 and 0",
               err_seen - e0, fifo_count);
    end
    ps2_frame(8'h5A, 0, 11, 0);
    drain("parity_recover");
  endtask

  task automatic test_timeout();
    int e0;
    e0 = err_seen;
    code_ready = 1'b1;
    ps2_frame(8'hA5, 0, 5, 0);
    tick(TMO + 20);
    exp_err++;
    vectors++;
    if (err_seen != e0 + 1 || fifo_count !== 4'd0) begin
      miscompares++;
      $display("FAIL timeout_err: pulses=%0d count=%0d, expected 1 and 0",
               err_seen - e0, fifo_count);
    end
    ps2_frame(8'h72, 0, 11, 0);
    drain("timeout_recover");
  endtask

  task automatic test_overflow();
    logic [7:0] codes [9];
    int p0;
    codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
    code_ready = 1'b0;
    for (int i = 0; i < 9; i++) ps2_frame(codes[i], 0, 11, 0);
    vectors++;
    if (fifo_count !== 4'd8 || overflow !== 1'b1 || code_data !== 10'h015) begin
      miscompares++;
      $display("FAIL overflow_full: count=%0d ovf=%b head=%h, expected 8 1 015",
               fifo_count, overflow, code_data);
    end
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    vectors++;
    if (overflow !== 1'b0 || fifo_count !== 4'd8) begin
      miscompares++;
      $display("FAIL overflow_clear: ovf=%b count=%0d, expected 0 and 8", overflow, fifo_count);
    end
    p0 = pops;
    code_ready = 1'b1;
    drain("overflow");
    vectors++;
    if (pops - p0 != 8) begin
      miscompares++;
      $display("FAIL overflow_drain_count: entries=%0d, expected 8", pops - p0);
    end
  endtask

  task automatic test_typematic();
    int p0;
    p0 = pops;
    code_ready = 1'b1;
    ps2_frame(8'h74, 0, 11, 0);
    ps2_frame(8'h74, 0, 11, 0);
    ps2_frame(8'h74, 0, 11, 0);
    ps2_frame(8'hF0, 0, 11, 0);
    ps2_frame(8'h74, 0, 11, 0);
    drain("typematic");
    vectors++;
    if (pops - p0 != TYPE_PUSHES) begin
      miscompares++;
      $display("FAIL typematic_count: entries=%0d, expected %0d", pops - p0, TYPE_PUSHES);
    end
  endtask

  task automatic test_mid_reset();
    code_ready = 1'b0;
    ps2_frame(8'h16, 0, 11, 0);
    ps2_frame(8'h1E, 0, 11, 0);
    ps2_frame(8'h26, 0, 11, 0);
    vectors++;
    if (fifo_count !== 4'd3) begin
      miscompares++;
      $display("FAIL midreset_fill: count=%0d, expected 3", fifo_count);
    end
    ps2_frame(8'h29, 0, 5, 0);
    rst = 1'b1;
    tick(2);
    vectors++;
    if (code_valid !== 1'b0 || fifo_count !== 4'd0 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_state: valid=%b count=%0d ovf=%b, expected 0 0 0",
               code_valid, fifo_count, overflow);
    end
    exp_q.delete();
    m_ext = 0; m_brk = 0; lm_v = 0;
    rst = 1'b0;
    tick(3);
    code_ready = 1'b1;
    ps2_frame(8'h29, 0, 11, 0);
    drain("midreset_recover");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_prefix();
    test_parity();
    test_timeout();
    test_overflow();
    test_typematic();
    test_mid_reset();
    vectors++;
    if (err_seen != exp_err) begin
      miscompares++;
      $display("FAIL frame_err_total: pulses=%0d, expected %0d", err_seen, exp_err);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
